// File: rtl/aes_pkg.sv
// Shared AES types, FSM encoding and GF(2^8) helpers for the SubBytes datapath.
// Inverse-S-box helpers are only compiled when SUB_BYTES_INV_EN is defined.
package aes_pkg;

    localparam int unsigned AES_STATE_W = 128;
    localparam int unsigned AES_NBYTES  = 16;

    typedef logic [AES_STATE_W-1:0] aes_state_t;
    typedef logic [7:0]             aes_byte_t;

    typedef enum logic [1:0] {IDLE, RUN, DONE} sub_fsm_t;

    function automatic aes_byte_t rotl8(aes_byte_t x, int unsigned n);
        return aes_byte_t'((x << n) | (x >> (8 - n)));
    endfunction

    function automatic aes_byte_t gf_mul(aes_byte_t a, aes_byte_t b);
        aes_byte_t p;
        aes_byte_t x;
        p = '0;
        x = a;
        for (int unsigned i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // a^254 == a^-1 in GF(2^8); zero maps to zero as AES requires
    function automatic aes_byte_t gf_inv(aes_byte_t a);
        aes_byte_t sq;
        aes_byte_t r;
        sq = a;
        r  = 8'h01;
        for (int unsigned i = 1; i < 8; i++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    function automatic aes_byte_t sbox_fwd(aes_byte_t a);
        aes_byte_t x;
        x = gf_inv(a);
        return x ^ rotl8(x, 1) ^ rotl8(x, 2) ^ rotl8(x, 3) ^ rotl8(x, 4) ^ 8'h63;
    endfunction

`ifdef SUB_BYTES_INV_EN
    function automatic aes_byte_t sbox_inv(aes_byte_t b);
        return gf_inv(rotl8(b, 1) ^ rotl8(b, 3) ^ rotl8(b, 6) ^ 8'h05);
    endfunction
`endif

endpackage

// File: rtl/sub_bytes_engine_sbox.sv
// Single-byte AES S-box lanes: forward sbox always, inv_sbox only under SUB_BYTES_INV_EN.
// Both are pure combinational 256-entry mappings.
module sbox
    import aes_pkg::*;
(
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);

    assign out_byte = sbox_fwd(in_byte);

endmodule

`ifdef SUB_BYTES_INV_EN
module inv_sbox
    import aes_pkg::*;
(
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);

    assign out_byte = sbox_inv(in_byte);

endmodule
`endif

// File: rtl/sub_bytes_engine.sv
// Sequential AES SubBytes: LANES bytes per cycle, 16/LANES RUN cycles per state.
// Define SUB_BYTES_INV_EN to add the inv port and per-lane InvSubBytes.
module sub_bytes_engine
    import aes_pkg::*;
#(
    parameter int unsigned LANES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
`ifdef SUB_BYTES_INV_EN
    input  logic         inv,
`endif
    input  logic [127:0] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);

    localparam int unsigned RUNLEN   = AES_NBYTES / LANES;
    localparam int unsigned CNT_W    = (RUNLEN > 1) ? $clog2(RUNLEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RUNLEN - 1);

    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
        $error("sub_bytes_engine: LANES must be 1, 2, 4, 8 or 16");
    end

    sub_fsm_t         state;
    sub_fsm_t         state_nx;
    aes_state_t       data;
    aes_state_t       data_run;
    logic [CNT_W-1:0] cnt;
    logic             capture;
    logic             step;

    aes_byte_t        bytes    [AES_NBYTES];
    aes_byte_t        lane_in  [LANES];
    aes_byte_t        lane_out [LANES];
    logic [3:0]       lane_idx [LANES];

`ifdef SUB_BYTES_INV_EN
    logic             inv_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        capture   = '0;
        step      = '0;
        in_ready  = '0;
        out_valid = '0;
        busy      = '0;
        unique case (state)
            IDLE: begin
                in_ready = '1;
                if (in_valid) begin
                    capture  = '1;
                    state_nx = RUN;
                end
            end
            RUN: begin
                busy = '1;
                step = '1;
                if (cnt == CNT_LAST) state_nx = DONE;
            end
            DONE: begin
                busy      = '1;
                out_valid = '1;
                in_ready  = out_ready;
                if (out_ready) begin
                    if (in_valid) begin
                        capture  = '1;
                        state_nx = RUN;
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        for (int unsigned i = 0; i < AES_NBYTES; i++) begin
            bytes[i] = data[127 - 8*i -: 8];
        end
    end

    for (genvar j = 0; j < LANES; j++) begin : g_lane
        assign lane_idx[j] = 4'(32'(cnt) * LANES + j);
        assign lane_in[j]  = bytes[lane_idx[j]];
`ifdef SUB_BYTES_INV_EN
        aes_byte_t fwd_b;
        aes_byte_t inv_b;
        sbox     u_sbox     (.in_byte(lane_in[j]), .out_byte(fwd_b));
        inv_sbox u_inv_sbox (.in_byte(lane_in[j]), .out_byte(inv_b));
        assign lane_out[j] = inv_q ? inv_b : fwd_b;
`else
        sbox     u_sbox     (.in_byte(lane_in[j]), .out_byte(lane_out[j]));
`endif
    end

    // Write-back by index compare keeps every slice constant while lanes move with cnt
    always_comb begin
        data_run = data;
        for (int unsigned i = 0; i < AES_NBYTES; i++) begin
            for (int unsigned j = 0; j < LANES; j++) begin
                if (lane_idx[j] == 4'(i)) data_run[127 - 8*i -: 8] = lane_out[j];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data  <= '0;
            cnt   <= '0;
`ifdef SUB_BYTES_INV_EN
            inv_q <= '0;
`endif
        end else if (capture) begin
            data  <= in_state;
            cnt   <= '0;
`ifdef SUB_BYTES_INV_EN
            inv_q <= inv;
`endif
        end else if (step) begin
            data <= data_run;
            if (cnt != CNT_LAST) cnt <= cnt + 1'b1;
        end
    end

    assign out_state = data;

endmodule

// File: tb/tb_sub_bytes_engine.sv
// Self-checking bench for sub_bytes_engine: five instances (LANES 4,1,2,8,16) share stimulus;
// a table-built S-box model supplies expected states.
module tb_sub_bytes_engine;

    localparam int NI = 5;
    localparam int LN [NI] = '{4, 1, 2, 8, 16};

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         out_ready;
    logic [127:0] in_state;
`ifdef SUB_BYTES_INV_EN
    logic         inv;
`endif
    logic [NI-1:0] ir;
    logic [NI-1:0] ov;
    logic [NI-1:0] bz;
    logic [127:0]  os [NI];

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] sb  [256];
    logic [7:0] isb [256];

    typedef struct {
        logic [127:0] din;
        logic         iv;
        logic [127:0] exp;
    } vec_t;

    vec_t vecs [$];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        sub_bytes_engine #(.LANES(LN[g])) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid),
            .in_ready  (ir[g]),
`ifdef SUB_BYTES_INV_EN
            .inv       (inv),
`endif
            .in_state  (in_state),
            .out_valid (ov[g]),
            .out_ready (out_ready),
            .out_state (os[g]),
            .busy      (bz[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, got no summary, required completion");
        $fatal(1);
    end

    function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    // S-box via generator walk: p steps by x3, q by its inverse, so sb[p] = affine(p^-1)
    task automatic build_tables();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b00};
            q = q ^ {q[3:0], 4'b0000};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ rotl(q, 1) ^ rotl(q, 2) ^ rotl(q, 3) ^ rotl(q, 4);
            sb[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sb[0] = 8'h63;
        for (int i = 0; i < 256; i++) isb[sb[i]] = 8'(i);
    endtask

    function automatic logic [127:0] model(input logic [127:0] s, input logic iv);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) begin
            logic [7:0] b;
            b = s[127 - 8*i -: 8];
            r[127 - 8*i -: 8] = iv ? isb[b] : sb[b];
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [127:0] s, input logic iv);
        in_state = s;
`ifdef SUB_BYTES_INV_EN
        inv = iv;
`else
        if (iv) $display("FAIL drive: inv vector in forward-only build, got 1 required 0");
`endif
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        bit seen [NI];
        bit all_seen;
        foreach (seen[i]) seen[i] = 1'b0;
        drive(v.din, v.iv);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            all_seen = 1'b1;
            for (int i = 0; i < NI; i++) begin
                if (!seen[i] && ov[i]) begin
                    seen[i] = 1'b1;
                    chk($sformatf("v%0d_lat_L%0d", idx, LN[i]), 128'(n), 128'(16 / LN[i] + 1));
                    chk($sformatf("v%0d_data_L%0d", idx, LN[i]), os[i], v.exp);
                end
                all_seen &= seen[i];
            end
            if (all_seen) break;
            step();
        end
        for (int i = 0; i < NI; i++) begin
            if (!seen[i]) chk($sformatf("v%0d_timeout_L%0d", idx, LN[i]), 128'(0), 128'(1));
        end
        step();
        chk($sformatf("v%0d_idle", idx), 128'(bz), 128'(0));
    endtask

    initial begin
        logic [127:0] r;
        bit done;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        drive('0, 1'b0);
        build_tables();

        vecs.push_back('{128'h0, 1'b0, {16{8'h63}}});
        vecs.push_back('{128'h193de3bea0f4e22b9ac68d2ae9f84808, 1'b0,
                         128'hd42711aee0bf98f1b8b45de51e415230});
        vecs.push_back('{{16{8'hff}}, 1'b0, {16{8'h16}}});
        for (int i = 0; i < 6; i++) begin
            r = {$urandom, $urandom, $urandom, $urandom};
            vecs.push_back('{r, 1'b0, model(r, 1'b0)});
        end
`ifdef SUB_BYTES_INV_EN
        vecs.push_back('{128'hd42711aee0bf98f1b8b45de51e415230, 1'b1,
                         128'h193de3bea0f4e22b9ac68d2ae9f84808});
        vecs.push_back('{{16{8'h63}}, 1'b1, 128'h0});
        for (int i = 0; i < 4; i++) begin
            r = {$urandom, $urandom, $urandom, $urandom};
            vecs.push_back('{r, 1'b1, model(r, 1'b1)});
        end
`endif

        #3;
        chk("rst_in_ready", 128'(ir), 128'({NI{1'b1}}));
        chk("rst_out_valid", 128'(ov), 128'(0));
        chk("rst_busy", 128'(bz), 128'(0));
        chk("rst_out_state", os[0], 128'h0);
        step();
        step();
        rst = 1'b0;
        step();

        foreach (vecs[k]) run_vec(vecs[k], k);

        // Reset landing in the middle of RUN
        drive({$urandom, $urandom, $urandom, $urandom}, 1'b0);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        chk("run_in_ready", 128'(ir[0]), 128'(0));
        chk("run_busy", 128'(bz[0]), 128'(1));
        rst = 1'b1;
        #1;
        chk("midrst_in_ready", 128'(ir), 128'({NI{1'b1}}));
        chk("midrst_out_valid", 128'(ov), 128'(0));
        chk("midrst_busy", 128'(bz), 128'(0));
        for (int i = 0; i < NI; i++) chk($sformatf("midrst_state_L%0d", LN[i]), os[i], 128'h0);
        step();
        rst = 1'b0;
        step();

        // Backpressure in DONE, then back-to-back capture on the releasing handshake
        out_ready = 1'b0;
        drive(128'h193de3bea0f4e22b9ac68d2ae9f84808, 1'b0);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        done = 1'b0;
        for (int n = 1; n <= 40 && !done; n++) begin
            if (ov[0]) begin
                done = 1'b1;
                chk("bp_lat", 128'(n), 128'(5));
            end else begin
                step();
            end
        end
        if (!done) chk("bp_timeout", 128'(0), 128'(1));
        for (int c = 0; c < 10; c++) begin
            step();
            chk($sformatf("bp_hold_state_%0d", c), os[0], 128'hd42711aee0bf98f1b8b45de51e415230);
            chk($sformatf("bp_hold_ctl_%0d", c), {ov[0], ir[0]}, 128'b10);
        end
        out_ready = 1'b1;
        drive(128'h0, 1'b0);
        in_valid = 1'b1;
        #1;
        chk("b2b_in_ready", 128'(ir[0]), 128'(1));
        step();
        in_valid = 1'b0;
        chk("b2b_busy", 128'(bz[0]), 128'(1));
        chk("b2b_out_valid", 128'(ov[0]), 128'(0));
        done = 1'b0;
        for (int n = 1; n <= 40 && !done; n++) begin
            if (ov[0]) begin
                done = 1'b1;
                chk("b2b_lat", 128'(n), 128'(5));
                chk("b2b_data", os[0], {16{8'h63}});
            end else begin
                step();
            end
        end
        if (!done) chk("b2b_timeout", 128'(0), 128'(1));

        done = 1'b0;
        for (int n = 0; n < 60 && !done; n++) begin
            step();
            if (bz == '0) done = 1'b1;
        end
        chk("drain_idle", 128'(bz), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
